// File: rtl/ldpc_column_sum_unit_pkg.sv
// Shared widths, FSM state type and ACC_W->W saturation for the LDPC decoder.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package ldpc_pkg;

  localparam int W       = 8;
  localparam int MAX_DEG = 6;
  localparam int DEG_W   = $clog2(MAX_DEG + 1);
  // Headroom for llr + MAX_DEG messages, so the column total never wraps.
  localparam int ACC_W   = W + $clog2(MAX_DEG + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE,
    ST_EMIT
  } state_t;

  // Clamp a wide two's-complement value into W bits. The value fits when all
  // bits from the W-1 sign position upward agree.
  function automatic logic [W-1:0] sat_w(input logic [ACC_W-1:0] v);
    if (v[ACC_W-1:W-1] == {(ACC_W-W+1){v[ACC_W-1]}})
      return v[W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(W-1){1'b0}}};
    else
      return {1'b0, {(W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/ldpc_column_sum_unit_if.sv
// Job/total/extrinsic bundle of the column-sum unit.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready for jobs, ext_valid/ext_ready for extrinsics.
// Ports: in_* = column job, total* = column total pulse, ext_* = extrinsic
// stream, busy = unit not idle. slave = unit side, master = producer/consumer.
interface ldpc_column_sum_unit_if;
  import ldpc_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [MAX_DEG*W-1:0] in_msgs;
  logic [W-1:0]         in_llr;
  logic [DEG_W-1:0]     in_deg;
  logic                 in_ext_en;
  logic                 total_valid;
  logic [ACC_W-1:0]     total;
  logic                 ext_valid;
  logic                 ext_ready;
  logic [W-1:0]         ext_data;
  logic [DEG_W-1:0]     ext_index;
  logic                 busy;

  modport slave (
    input  in_valid, in_msgs, in_llr, in_deg, in_ext_en, ext_ready,
    output in_ready, total_valid, total, ext_valid, ext_data, ext_index, busy
  );

  modport master (
    output in_valid, in_msgs, in_llr, in_deg, in_ext_en, ext_ready,
    input  in_ready, total_valid, total, ext_valid, ext_data, ext_index, busy
  );

endinterface

// File: rtl/ldpc_sat_narrow.sv
// Saturating narrower from ACC_W to W bits, also used by the row-sum path.
// Latency: combinational.
// Backpressure: none.
// Ports: i_dat = wide signed value, o_dat = value clamped to the W-bit range.
module ldpc_sat_narrow
  import ldpc_pkg::*;
(
  input  logic [ACC_W-1:0] i_dat,
  output logic [W-1:0]     o_dat
);

  assign o_dat = sat_w(i_dat);

endmodule

// File: rtl/ldpc_column_sum_unit.sv
// Column sum: llr + deg messages through one shared adder, then leave-one-out extrinsics.
// Latency: total_valid deg edges after accept; extrinsics follow one per cycle.
// Backpressure: one job at a time (in_ready only in IDLE); ext stream holds while ext_ready=0.
// Ports: clk, clr (async active-low), bus = job/total/extrinsic interface (slave side).
module ldpc_column_sum_unit
  import ldpc_pkg::*;
(
  input logic                  clk,
  input logic                  clr,
  ldpc_column_sum_unit_if.slave bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [MAX_DEG*W-1:0] r_msgs;
  logic [ACC_W-1:0]     r_acc;
  logic [DEG_W-1:0]     r_idx;
  logic [DEG_W-1:0]     r_deg;
  logic                 r_ext_en;

  logic [DEG_W-1:0]     w_deg_clamp;
  logic [W-1:0]         w_msg;
  logic [ACC_W-1:0]     w_msg_sext;
  logic [ACC_W-1:0]     w_addsub;
  logic [W-1:0]         w_ext_dat;
  logic                 w_last;

  assign w_deg_clamp = (bus.in_deg > DEG_W'(MAX_DEG)) ? DEG_W'(MAX_DEG) : bus.in_deg;

  // Message mux; an idx past the last lane selects zero, never an X.
  always_comb begin
    w_msg = '0;
    for (int i = 0; i < MAX_DEG; i++) begin
      if (r_idx == DEG_W'(i)) w_msg = r_msgs[i*W +: W];
    end
  end

  assign w_msg_sext = {{(ACC_W-W){w_msg[W-1]}}, w_msg};

  // Single adder/subtractor: accumulates in ACCUM, forms total - msg in EMIT.
  // acc is frozen in EMIT, so it doubles as the stable total.
  assign w_addsub = (r_state == ST_EMIT) ? (r_acc - w_msg_sext) : (r_acc + w_msg_sext);
  assign w_last   = (r_idx == (r_deg - DEG_W'(1)));

  ldpc_sat_narrow u_sat (
    .i_dat (w_addsub),
    .o_dat (w_ext_dat)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.in_ready    = 1'b0;
    bus.total_valid = 1'b0;
    bus.ext_valid   = 1'b0;
    bus.busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) w_state_nxt = (w_deg_clamp != '0) ? ST_ACCUM : ST_DONE;
      end
      ST_ACCUM: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.total_valid = 1'b1;
        w_state_nxt     = (r_ext_en && (r_deg != '0)) ? ST_EMIT : ST_IDLE;
      end
      ST_EMIT: begin
        bus.ext_valid = 1'b1;
        if (bus.ext_ready && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_msgs   <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_deg    <= '0;
      r_ext_en <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_msgs   <= bus.in_msgs;
            r_acc    <= {{(ACC_W-W){bus.in_llr[W-1]}}, bus.in_llr};
            r_deg    <= w_deg_clamp;
            r_ext_en <= bus.in_ext_en;
            r_idx    <= '0;
          end
        end
        ST_ACCUM: begin
          r_acc <= w_addsub;
          r_idx <= r_idx + DEG_W'(1);
        end
        ST_DONE: r_idx <= '0;
        ST_EMIT: begin
          if (bus.ext_ready) r_idx <= r_idx + DEG_W'(1);
        end
        default: r_idx <= '0;
      endcase
    end
  end

  assign bus.total     = r_acc;
  assign bus.ext_data  = w_ext_dat;
  assign bus.ext_index = r_idx;

endmodule

// File: tb/tb_ldpc_column_sum_unit.sv
module tb_ldpc_column_sum_unit;
  import ldpc_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  ldpc_column_sum_unit_if bus();

  ldpc_column_sum_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int jm[MAX_DEG];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_deg(input int d);
    return (d > MAX_DEG) ? MAX_DEG : d;
  endfunction

  function automatic int sat_ref(input int v);
    int hi = (1 << (W-1)) - 1;
    int lo = -(1 << (W-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int rnd_msg();
    return int'($urandom_range(255)) - 128;
  endfunction

  // Offer one job using jm[] as messages and check the whole transaction.
  task automatic run_job(input int llr, input int deg_raw, input bit ext_en,
                         input int stall_idx, input int stall_len, input bit junk,
                         output int tot_obs);
    int deg = clamp_deg(deg_raw);
    int exp_tot = llr;
    int cyc = 0;
    logic [MAX_DEG*W-1:0] pk;
    for (int i = 0; i < MAX_DEG; i++) pk[i*W +: W] = W'(jm[i]);
    for (int i = 0; i < deg; i++) exp_tot += jm[i];

    chk("idle_ready", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_msgs   = pk;
    bus.in_llr    = W'(llr);
    bus.in_deg    = DEG_W'(deg_raw);
    bus.in_ext_en = ext_en;
    @(negedge clk);
    // Offers while busy must be ignored and must not disturb the captured job.
    bus.in_valid = junk;
    if (junk) begin
      bus.in_msgs = {$urandom, $urandom};
      bus.in_llr  = W'($urandom);
    end
    while (!bus.total_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("total_latency", cyc, deg);
    chk("total", $signed(bus.total), exp_tot);
    tot_obs = int'($signed(bus.total));
    @(negedge clk);
    chk("total_valid_pulse", bus.total_valid, 0);
    if (ext_en && deg > 0) begin
      for (int i = 0; i < deg; i++) begin
        int e = sat_ref(exp_tot - jm[i]);
        if (i == stall_idx) begin
          bus.ext_ready = 1'b0;
          for (int s = 0; s < stall_len; s++) begin
            chk("stall_ext_valid", bus.ext_valid, 1);
            chk("stall_ext_index", bus.ext_index, i);
            chk("stall_ext_data", $signed(bus.ext_data), e);
            chk("stall_in_ready", bus.in_ready, 0);
            @(negedge clk);
          end
          bus.ext_ready = 1'b1;
        end
        chk("ext_valid", bus.ext_valid, 1);
        chk("ext_index", bus.ext_index, i);
        chk("ext_data", $signed(bus.ext_data), e);
        @(negedge clk);
      end
    end
    chk("end_in_ready", bus.in_ready, 1);
    chk("end_ext_valid", bus.ext_valid, 0);
    chk("end_busy", bus.busy, 0);
    chk("total_hold", $signed(bus.total), exp_tot);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_total_valid"}, bus.total_valid, 0);
    chk({tag, "_ext_valid"}, bus.ext_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_total"}, $signed(bus.total), 0);
  endtask

  // Start a deg-6 extrinsic job with ext stalled, then pull clr after n_wait cycles.
  task automatic reset_mid(input int n_wait, input bit expect_emit);
    logic [MAX_DEG*W-1:0] pk;
    for (int i = 0; i < MAX_DEG; i++) pk[i*W +: W] = W'(rnd_msg());
    bus.ext_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_msgs   = pk;
    bus.in_llr    = W'(40);
    bus.in_deg    = DEG_W'(6);
    bus.in_ext_en = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n_wait) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_ext_valid", bus.ext_valid, expect_emit);
    clr = 1'b0;
    #1;
    check_reset_outputs(expect_emit ? "rst_emit" : "rst_accum");
    @(negedge clk);
    clr = 1'b1;
    bus.ext_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_total_valid", bus.total_valid, 0);
    chk("post_rst_ext_valid", bus.ext_valid, 0);
    chk("post_rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tot;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_msgs   = '0;
    bus.in_llr    = '0;
    bus.in_deg    = '0;
    bus.in_ext_en = 1'b0;
    bus.ext_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    clr = 1'b1;
    @(negedge clk);
    chk("reset_release_ready", bus.in_ready, 1);

    // Basic; lanes above deg carry junk that must be ignored.
    jm = '{10, -20, 5, 99, 99, 99};
    run_job(7, 3, 1'b1, -1, 0, 1'b0, tot);
    chk("basic_total", tot, 2);

    jm = '{127, 127, 127, 127, 127, 127};
    run_job(127, 6, 1'b1, -1, 0, 1'b0, tot);
    chk("pos_sat_total", tot, 889);

    jm = '{-128, -128, -128, -128, -128, -128};
    run_job(-128, 6, 1'b1, -1, 0, 1'b0, tot);
    chk("neg_sat_total", tot, -896);

    jm = '{33, 33, 33, 33, 33, 33};
    run_job(-5, 0, 1'b1, -1, 0, 1'b0, tot);
    chk("deg0_total", tot, -5);

    jm = '{1, 2, 3, 4, 5, 6};
    run_job(0, 7, 1'b1, -1, 0, 1'b0, tot);
    chk("deg7_clamp_total", tot, 21);

    jm = '{10, -20, 5, 0, 0, 0};
    run_job(7, 3, 1'b1, 1, 4, 1'b0, tot);

    jm = '{-3, 8, 0, 0, 0, 0};
    run_job(100, 2, 1'b0, -1, 0, 1'b1, tot);
    chk("no_ext_total", tot, 105);

    reset_mid(2, 1'b0);
    jm = '{10, -20, 5, 0, 0, 0};
    run_job(7, 3, 1'b1, -1, 0, 1'b0, tot);
    reset_mid(8, 1'b1);
    jm = '{127, 127, 127, 127, 127, 127};
    run_job(127, 6, 1'b1, -1, 0, 1'b0, tot);

    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < MAX_DEG; i++) jm[i] = rnd_msg();
      run_job(rnd_msg(), int'($urandom_range(7)), 1'($urandom_range(1)),
              int'($urandom_range(6)), int'($urandom_range(3)), 1'($urandom_range(1)), tot);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
